// File: rtl/riscv_pkg.sv
// Shared RISC-V constants, fetch FSM states and fault encodings.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fault_cause_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts unanswered fetch cycles; flags expiry on the last allowed cycle.
module fetch_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic incr,
  output logic expired_c
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Wait counter: cleared by reset or ack, bumped on each unanswered cycle
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + CNT_W'(1);
    end
  end

  // Expiry only when enabled and this cycle is itself unanswered
  always_comb begin
    expired_c = (ACK_TIMEOUT != 0) && incr && (count == LIMIT);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/ack handshake, instruction hold and PC commit.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int unsigned      ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            exec_done,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [31:0]     retire_count
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc_nxt, branch_pc;
  logic [31:0]     instr_nxt, retire_nxt;
  logic            fault_nxt;
  logic [1:0]      cause_nxt;
  logic            wd_clear, wd_incr, wd_expired_c;

  fetch_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clear),
    .incr      (wd_incr),
    .expired_c (wd_expired_c)
  );

  // Field decode straight off the held instruction register
  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);
  assign op        = instr[6:0];
  assign func3     = instr[14:12];
  assign func7     = instr[31:25];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign rd        = instr[11:7];

  // Next-state and next-register values
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    instr_nxt  = instr;
    fault_nxt  = fault;
    cause_nxt  = fault_cause;
    retire_nxt = retire_count;
    wd_clear   = 1'b0;
    wd_incr    = 1'b0;
    branch_pc  = pc_src ? pc_target : pc_plus4;

    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          wd_clear  = 1'b1;
          state_nxt = S_EXEC;
        end else begin
          wd_incr = 1'b1;
          if (wd_expired_c) begin
            fault_nxt = 1'b1;
            cause_nxt = 2'(FC_TIMEOUT);
            state_nxt = S_FAULT;
          end
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          retire_nxt = retire_count + 32'd1;
          if (branch_pc[1:0] != 2'b00) begin
            fault_nxt = 1'b1;
            cause_nxt = 2'(FC_MISALIGN);
            state_nxt = S_FAULT;
          end else begin
            pc_nxt    = branch_pc;
            state_nxt = S_FETCH;
          end
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_RESET;
    endcase
  end

  // State and output registers; req/valid registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RESET;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      fault        <= 1'b0;
      fault_cause  <= 2'(FC_NONE);
      retire_count <= 32'd0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      instr        <= instr_nxt;
      instr_valid  <= (state_nxt == S_EXEC);
      imem_req     <= (state_nxt == S_FETCH);
      fault        <= fault_nxt;
      fault_cause  <= cause_nxt;
      retire_count <= retire_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against a behavioural fetch model.
module tb_instr_fetch_unit;

  localparam int unsigned TMO = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] pc, pc_plus4;
  logic        exec_done;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] retire_count;

  instr_fetch_unit #(
    .XLEN        (32),
    .RESET_PC    (32'h0),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .op           (op),
    .func3        (func3),
    .func7        (func7),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .exec_done    (exec_done),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .fault        (fault),
    .fault_cause  (fault_cause),
    .retire_count (retire_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: what the fetch stage is doing, not how
  typedef enum {M_BOOT, M_WAIT_MEM, M_HOLD, M_DEAD} mode_t;
  mode_t       m_mode;
  logic [31:0] m_pc, m_instr, m_retire;
  logic        m_fault;
  logic [1:0]  m_cause;
  int unsigned m_misses;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    if (rst) begin
      m_mode   = M_BOOT;
      m_pc     = 32'h0;
      m_instr  = 32'h0000_0013;
      m_fault  = 1'b0;
      m_cause  = 2'd0;
      m_retire = 32'd0;
      m_misses = 0;
    end else begin
      case (m_mode)
        M_BOOT: m_mode = M_WAIT_MEM;
        M_WAIT_MEM: begin
          if (imem_ack) begin
            m_instr  = imem_rdata;
            m_misses = 0;
            m_mode   = M_HOLD;
          end else begin
            m_misses++;
            if (m_misses == TMO) begin
              m_fault = 1'b1;
              m_cause = 2'd2;
              m_mode  = M_DEAD;
            end
          end
        end
        M_HOLD: begin
          if (exec_done) begin
            m_retire = m_retire + 32'd1;
            nxt = pc_src ? pc_target : m_pc + 32'd4;
            if ((nxt % 4) != 0) begin
              m_fault = 1'b1;
              m_cause = 2'd1;
              m_mode  = M_DEAD;
            end else begin
              m_pc   = nxt;
              m_mode = M_WAIT_MEM;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("imem_req",     32'(imem_req),     32'(m_mode == M_WAIT_MEM));
    chk("instr_valid",  32'(instr_valid),  32'(m_mode == M_HOLD));
    chk("imem_addr",    imem_addr,         m_pc);
    chk("pc",           pc,                m_pc);
    chk("pc_plus4",     pc_plus4,          m_pc + 32'd4);
    chk("instr",        instr,             m_instr);
    chk("op",           32'(op),           32'(m_instr[6:0]));
    chk("func3",        32'(func3),        32'(m_instr[14:12]));
    chk("func7",        32'(func7),        32'(m_instr[31:25]));
    chk("rs1",          32'(rs1),          32'(m_instr[19:15]));
    chk("rs2",          32'(rs2),          32'(m_instr[24:20]));
    chk("rd",           32'(rd),           32'(m_instr[11:7]));
    chk("fault",        32'(fault),        32'(m_fault));
    chk("fault_cause",  32'(fault_cause),  32'(m_cause));
    chk("retire_count", retire_count,      m_retire);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] d,
                       input logic done, input logic src, input logic [31:0] tgt);
    rst        = r;
    imem_ack   = a;
    imem_rdata = d;
    exec_done  = done;
    pc_src     = src;
    pc_target  = tgt;
  endtask

  initial begin
    m_mode = M_BOOT; m_pc = 0; m_instr = 32'h13; m_retire = 0;
    m_fault = 0; m_cause = 0; m_misses = 0;

    // Reset values
    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk("rst_req",    32'(imem_req),    32'd0);
    chk("rst_valid",  32'(instr_valid), 32'd0);
    chk("rst_instr",  instr,            32'h0000_0013);
    chk("rst_addr",   imem_addr,        32'h0);

    // First fetch; an ack during the reset-exit cycle is ignored
    drive(0, 1, 32'h0050_0093, 0, 0, 0);
    tick();
    chk("boot_req",   32'(imem_req),    32'd1);
    chk("boot_instr", instr,            32'h0000_0013);
    tick();
    chk("t1_valid",   32'(instr_valid), 32'd1);
    chk("t1_op",      32'(op),          32'h13);
    chk("t1_rd",      32'(rd),          32'd1);
    chk("t1_func3",   32'(func3),       32'd0);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    chk("t1_addr",    imem_addr,        32'h4);
    chk("t1_retire",  retire_count,     32'd1);

    // Taken branch to an aligned target
    drive(0, 1, 32'h0000_0033, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 1, 32'h100);
    tick();
    chk("t2_addr",    imem_addr,        32'h100);
    chk("t2_fault",   32'(fault),       32'd0);

    // Misaligned target faults, later acks ignored
    drive(0, 1, 32'h0020_8133, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 1, 32'h102);
    tick();
    chk("t3_fault",   32'(fault),       32'd1);
    chk("t3_cause",   32'(fault_cause), 32'd1);
    chk("t3_pc",      pc,               32'h100);
    chk("t3_retire",  retire_count,     32'd3);
    drive(0, 1, 32'hdead_beef, 1, 0, 0);
    repeat (3) tick();
    chk("t3_instr",   instr,            32'h0020_8133);
    chk("t3_req",     32'(imem_req),    32'd0);

    // Ack timeout after four unanswered request cycles
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    repeat (3) tick();
    chk("t4_nofault", 32'(fault),       32'd0);
    tick();
    chk("t4_fault",   32'(fault),       32'd1);
    chk("t4_cause",   32'(fault_cause), 32'd2);

    // Ack on the fourth request cycle wins over expiry
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    repeat (3) tick();
    drive(0, 1, 32'h00c5_8533, 0, 0, 0);
    tick();
    chk("t4b_valid",  32'(instr_valid), 32'd1);
    chk("t4b_fault",  32'(fault),       32'd0);
    chk("t4b_instr",  instr,            32'h00c5_8533);

    // Reset in fetch, stray ack in the following cycle
    drive(0, 0, 0, 1, 0, 0);
    tick();
    chk("t5_addr",    imem_addr,        32'h4);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 32'hffff_ffff, 0, 0, 0);
    tick();
    chk("t5_instr",   instr,            32'h0000_0013);
    chk("t5_addr0",   imem_addr,        32'h0);
    chk("t5_valid",   32'(instr_valid), 32'd0);
    tick();

    // PC wrap at the top of the address space
    drive(0, 0, 0, 1, 1, 32'hffff_fffc);
    tick();
    chk("t6_addr",    imem_addr,        32'hffff_fffc);
    drive(0, 1, 32'h0000_0013, 0, 0, 0);
    tick();
    chk("t6_plus4",   pc_plus4,         32'h0);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    chk("t6_wrap",    imem_addr,        32'h0);
    chk("t6_fault",   32'(fault),       32'd0);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      rst        = (m_mode == M_DEAD) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      imem_ack   = ($urandom_range(0, 9) < 7);
      imem_rdata = $urandom;
      exec_done  = 1'($urandom_range(0, 1));
      pc_src     = 1'($urandom_range(0, 1));
      pc_target  = $urandom;
      if ($urandom_range(0, 9) < 8) pc_target[1:0] = 2'b00;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that feeds the control unit and datapath. It holds the PC and runs a req/ack handshake with instruction memory. It latches the returned word and presents op/func3/func7 and register fields until the core signals execution complete. It then steps the PC by 4, or redirects it to a branch target, and detects misaligned targets and memory timeouts.

Parameters:
XLEN, 32, PC/instruction data width
RESET_PC, 32'h0000_0000, PC loaded on reset
ACK_TIMEOUT, 255, max cycles waiting for imem_ack before fault (0 disables watchdog)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  instruction read request
imem_addr  out  XLEN  read address (= pc)
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
instr_valid  out  1  held instruction is valid for execution
instr  out  32  held instruction word
op  out  7  instr[6:0]
func3  out  3  instr[14:12]
func7  out  7  instr[31:25]
rs1, rs2, rd  out  5 each  instr[19:15], [24:20], [11:7]
pc  out  XLEN  address of held instruction
pc_plus4  out  XLEN  pc + 4
exec_done  in  1  core finished current instruction; commit next PC
pc_src  in  1  1 = take pc_target (branch/jump taken)
pc_target  in  XLEN  redirect address
fault  out  1  sticky fault flag
fault_cause  out  2  0 none, 1 misaligned target, 2 ack timeout
retire_count  out  32  instructions retired, wraps

Behaviour:
- Reset applies on a clk edge with rst=1 in any state; rst wins over every other input.
- Reset values: pc=RESET_PC, state=S_RESET, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fault=0, fault_cause=0, retire_count=0, watchdog=0.
- Outputs are decoded from registered state and the instr register, so they have no combinational path from imem_*, exec_done or pc_src.
- imem_addr = pc at all times; pc_plus4 = pc+4 mod 2^XLEN (wraps 0xFFFF_FFFC -> 0).
- FSM states: S_RESET, S_FETCH, S_EXEC, S_FAULT.
- S_RESET: single cycle, always moves to S_FETCH. imem_ack is ignored.
- S_FETCH:
  - imem_req=1, address held stable.
  - On imem_ack: instr<=imem_rdata, watchdog<=0, go to S_EXEC.
  - Otherwise watchdog++. If ACK_TIMEOUT!=0 and watchdog reaches ACK_TIMEOUT-1 without ack: fault<=1, fault_cause<=2, go to S_FAULT.
- S_EXEC:
  - instr_valid=1, imem_req=0.
  - On exec_done: next = pc_src ? pc_target : pc+4, retire_count++.
  - If next[1:0]!=0: pc is unchanged, fault<=1, fault_cause<=1, go to S_FAULT. The faulting instruction still counts as retired.
  - Else pc<=next, go to S_FETCH.
- S_FAULT: absorbing until rst. instr_valid=0, imem_req=0, all inputs ignored.
- Latency:
  - ack in cycle N -> instr_valid=1 in cycle N+1.
  - exec_done in cycle M -> imem_req=1 with the new address in cycle M+1.
  - Minimum 2 cycles per instruction (ack in the same cycle as req, exec_done in the first S_EXEC cycle).
- Ignored events:
  - imem_ack outside S_FETCH, including a late ack after reset or fault.
  - exec_done outside S_EXEC.
  - pc_src/pc_target when exec_done=0.
- instr, and hence op/func3/func7, hold their last value outside S_EXEC. Downstream must qualify with instr_valid.
- Simultaneous imem_ack and watchdog expiry in the same cycle: the ack wins.
- retire_count wraps 0xFFFF_FFFF -> 0.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - NOP encoding 32'h0000_0013
  - fetch state enum
  - fault_cause encodings
- One natural sub-module: fetch_watchdog (load/clear/increment counter with an expiry compare against ACK_TIMEOUT). All other logic stays in instr_fetch_unit.

Test Plan:
1. Reset, then ack the first request immediately with 32'h00500093 -> addr 0x0 requested; next cycle instr_valid=1, op=7'h13, rd=1, func3=0. exec_done, pc_src=0 -> next imem_addr=0x4, retire_count=1.
2. In S_EXEC, exec_done=1, pc_src=1, pc_target=0x100 -> imem_addr=0x100 one cycle later, no fault.
3. exec_done with pc_src=1, pc_target=0x102 -> fault=1, fault_cause=1, pc stays at old value, instr_valid=0, imem_req=0. Later acks ignored until rst.
4. ACK_TIMEOUT=4, hold imem_ack=0 -> fault_cause=2 after 4 request cycles. Repeat with ack on the 4th cycle -> no fault, instr latched.
5. Assert rst in S_FETCH with an ack in the following cycle -> pc=RESET_PC, instr=NOP, instr_valid=0. Stray ack does not load instr; fetch restarts at RESET_PC.
6. Preload retire_count near wrap via 2^32-1 retirements (or force) and run one more -> retire_count=0. pc=0xFFFF_FFFC with pc_src=0 -> pc_plus4=0, next fetch at 0x0.
